// File: rtl/scale_pkg.sv
// Shared types for the scale controller: scale codes, FSM states, and the
// button cycle order.
package scale_pkg;

  localparam int unsigned SCALE_W  = 2;
  localparam int unsigned HCOUNT_W = 11;
  localparam int unsigned VCOUNT_W = 10;

  typedef enum logic [SCALE_W-1:0] {
    SCALE_1X = 2'b00,
    SCALE_2X = 2'b11,
    SCALE_4X = 2'b10
  } scale_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_PEND   = 2'b01,
    ST_COMMIT = 2'b10
  } state_t;

  // Button cycle order 1x -> 2x -> 4x -> 1x
  function automatic scale_t next_scale(input scale_t cur);
    case (cur)
      SCALE_1X: return SCALE_2X;
      SCALE_2X: return SCALE_4X;
      default:  return SCALE_1X;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioning: 2-flop synchronizer, optional debounce filter
// (SCALE_CTRL_DEBOUNCE_EN), and rising-edge detect of the conditioned level.
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 371250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic rise_c
);

  logic sync_meta;
  logic sync_q;
  logic level;
  logic level_d;

  // Two-stage synchronizer for the asynchronous button level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      sync_meta <= btn;
      sync_q    <= sync_meta;
    end
  end

`ifdef SCALE_CTRL_DEBOUNCE_EN
  localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic [CNT_W-1:0] cnt;

  // Accept a new level only after it has been stable for DB_CYCLES cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (sync_q == level) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DB_CYCLES - 1)) begin
      level <= sync_q;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end
`else
  assign level = sync_q;
`endif

  // Previous conditioned level for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_d <= 1'b0;
    end else begin
      level_d <= level;
    end
  end

  assign rise_c = level & ~level_d;

endmodule

// File: rtl/scale_ctrl.sv
// Scale controller: collects button / forced scale requests and commits the
// pending scale exactly at the frame boundary so a new scale starts cleanly
// on the next frame. Optional debounce via SCALE_CTRL_DEBOUNCE_EN.
module scale_ctrl
  import scale_pkg::*;
#(
  parameter int unsigned H_TOTAL   = 1650,
  parameter int unsigned V_TOTAL   = 750,
  parameter int unsigned DB_CYCLES = 371250
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic                btn_in,
  input  logic                force_valid_in,
  input  logic [SCALE_W-1:0]  force_scale_in,
  output logic                force_ready_out,
  input  logic [HCOUNT_W-1:0] hcount_in,
  input  logic [VCOUNT_W-1:0] vcount_in,
  output logic [SCALE_W-1:0]  scale_out,
  output logic                scale_changed_out,
  output logic                err_out,
  output logic                busy_out
);

  state_t state;
  scale_t pending;

  logic   rise_c;
  logic   xfer_c;
  logic   illegal_c;
  logic   boundary_c;
  logic   take_c;
  scale_t base_c;
  scale_t update_c;

  btn_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_btn_debounce (
    .clk    (clk_in),
    .rst_n  (rst_n_in),
    .btn    (btn_in),
    .rise_c (rise_c)
  );

  // Request arbitration: a force transfer always beats a button event
  always_comb begin
    xfer_c     = force_valid_in && force_ready_out;
    illegal_c  = (force_scale_in == 2'b01);
    boundary_c = (hcount_in == HCOUNT_W'(H_TOTAL - 1)) &&
                 (vcount_in == VCOUNT_W'(V_TOTAL - 1));
    base_c     = (state == ST_IDLE) ? scale_t'(scale_out) : pending;
    update_c   = base_c;
    take_c     = 1'b0;
    if (xfer_c) begin
      if (!illegal_c) begin
        update_c = scale_t'(force_scale_in);
        take_c   = 1'b1;
      end
    end else if (rise_c) begin
      update_c = next_scale(base_c);
      take_c   = 1'b1;
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state             <= ST_IDLE;
      pending           <= SCALE_1X;
      scale_out         <= SCALE_1X;
      scale_changed_out <= 1'b0;
      err_out           <= 1'b0;
      busy_out          <= 1'b0;
      force_ready_out   <= 1'b1;
    end else begin
      scale_changed_out <= 1'b0;
      err_out           <= xfer_c && illegal_c;
      case (state)
        ST_IDLE: begin
          // A request taken on the boundary itself waits for the next one
          if (take_c) begin
            pending  <= update_c;
            state    <= ST_PEND;
            busy_out <= 1'b1;
          end
        end
        ST_PEND: begin
          if (take_c) begin
            pending <= update_c;
          end
          if (boundary_c) begin
            scale_out         <= update_c;
            scale_changed_out <= 1'b1;
            state             <= ST_COMMIT;
            force_ready_out   <= 1'b0;
          end
        end
        ST_COMMIT: begin
          state           <= ST_IDLE;
          busy_out        <= 1'b0;
          force_ready_out <= 1'b1;
        end
        default: begin
          state           <= ST_IDLE;
          busy_out        <= 1'b0;
          force_ready_out <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/scale_ctrl.md
SCALE_CTRL -- requirements
Module: scale_ctrl

Interface
REQ-001 SHALL have parameter H_TOTAL, default 1650: horizontal counts per line.
REQ-002 SHALL have parameter V_TOTAL, default 750: lines per frame.
REQ-003 SHALL have parameter DB_CYCLES, default 371250: debounce stability window in clk_in cycles.
REQ-004 SHALL have port clk_in, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n_in, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port btn_in, input, 1: raw, asynchronous scale-cycle button level.
REQ-007 SHALL have ports force_valid_in (input, 1) and force_scale_in (input, 2): override request; force_ready_out (output, 1) is its ready.
REQ-008 SHALL have ports hcount_in (input, 11) and vcount_in (input, 10): current raster position.
REQ-009 SHALL have port scale_out, output, 2: committed scale code to the scaling datapath.
REQ-010 SHALL have ports scale_changed_out, err_out and busy_out, output, 1 each.

Function
REQ-011 Legal scale codes SHALL be 2'b00 (1x), 2'b11 (2x) and 2'b10 (4x); 2'b01 SHALL be illegal.
REQ-012 Button cycle order SHALL be 00 -> 11 -> 10 -> 00.
REQ-013 btn_in SHALL pass through a 2-flop synchronizer; an event is a rising edge of the conditioned level.
REQ-014 Frame boundary SHALL be the single cycle with hcount_in==H_TOTAL-1 and vcount_in==V_TOTAL-1.
REQ-015 FSM states SHALL be IDLE, PEND, COMMIT.
REQ-016 IDLE: button event -> PEND, pending = next(scale_out); accepted legal force -> PEND, pending = force_scale_in.
REQ-017 PEND: button event sets pending = next(pending); accepted legal force overwrites pending; frame boundary -> COMMIT.
REQ-018 COMMIT: scale_out <= pending, scale_changed_out high for exactly this one cycle, -> IDLE next cycle.
REQ-019 scale_out SHALL change only on the COMMIT transition, so the new scale applies from the first pixel of the next frame.
REQ-020 force_ready_out SHALL be high in IDLE and PEND, low in COMMIT; transfer occurs when valid and ready are both high.
REQ-021 Transfer with force_scale_in==2'b01 SHALL be consumed, leave state and pending unchanged, and pulse err_out for one cycle.
REQ-022 A button event and a force transfer in the same cycle: force wins and the button event SHALL be dropped.
REQ-023 A request accepted in IDLE on the boundary cycle itself SHALL wait for the next frame boundary.
REQ-024 Events arriving during COMMIT SHALL be dropped: button events ignored, force held off by ready low.
REQ-025 busy_out SHALL be high whenever the state is not IDLE.

Reset
REQ-026 While rst_n_in is low: state=IDLE, scale_out=2'b00, pending=2'b00, synchronizer and debounce state cleared, scale_changed_out=err_out=busy_out=0, force_ready_out=1.
REQ-027 Reset asserted during PEND SHALL discard the pending value; no commit occurs after release.

Configuration
REQ-028 With SCALE_CTRL_DEBOUNCE_EN defined, the conditioned level SHALL update only after the synchronized input holds a new value for DB_CYCLES consecutive cycles; the counter restarts on any change.
REQ-029 Without SCALE_CTRL_DEBOUNCE_EN, the conditioned level SHALL be the synchronizer output directly, and DB_CYCLES SHALL be unused.

Structure
REQ-030 Package scale_pkg SHALL hold scale_t (SCALE_1X=2'b00, SCALE_2X=2'b11, SCALE_4X=2'b10), the FSM state enum, and function next_scale.
REQ-031 Synchronizer and debounce SHALL be sub-module btn_debounce, instantiated once.

Verification
REQ-032 H_TOTAL=8, V_TOTAL=4, DB_CYCLES=4; one clean button press mid-frame -> scale_out 00->11 the cycle after (h=7,v=3); one scale_changed_out pulse.
REQ-033 Three presses within one frame -> single commit to 00 (00->11->10->00); scale_changed_out still pulses once.
REQ-034 Force 2'b10 and button event in the same cycle in IDLE -> commit to 10; button ignored.
REQ-035 Force 2'b01 -> err_out one-cycle pulse; state stays IDLE; scale_out unchanged.
REQ-036 Debounce on: 2-cycle glitches on btn_in -> no state change. Debounce off: the same glitches -> PEND.
REQ-037 Reset asserted in PEND with pending=11 -> after release scale_out stays 00 through two full frames.
